// File: rtl/oam_dma_engine.sv
// rtl/oam_dma_engine.sv - sprite-table DMA: halts the CPU and copies one page to a fixed write port
module oam_dma_engine #(
   parameter int                ADDR_W    = 16,
   parameter int                DATA_W    = 8,
   parameter int                XFER_LEN  = 256,
   parameter logic [ADDR_W-1:0] TRIG_ADDR = 16'h4014,
   parameter logic [ADDR_W-1:0] DEST_ADDR = 16'h2004
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_we,
   input  logic [DATA_W-1:0] cpu_do,
   input  logic [DATA_W-1:0] bus_di,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_we,
   output logic [DATA_W-1:0] bus_do,
   output logic              cpu_rdy,
   output logic              dma_active,
   output logic              dma_done
);

   localparam int IDX_W = $clog2(XFER_LEN + 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_HALT  = 3'd1;
   localparam logic [2:0] ST_ALIGN = 3'd2;
   localparam logic [2:0] ST_READ  = 3'd3;
   localparam logic [2:0] ST_WRITE = 3'd4;

   logic [2:0]        state;
   logic              parity;
   logic [IDX_W-1:0]  index;
   logic [7:0]        page;
   logic [DATA_W-1:0] data_q;
   logic              done_q;

   logic              trigger;
   logic [IDX_W-1:0]  index_inc;
   logic [ADDR_W-1:0] src_addr;

   assign trigger   = (state == ST_IDLE) && cpu_we && (cpu_addr == TRIG_ADDR);
   assign index_inc = index + 1'b1;
   assign src_addr  = ADDR_W'({page, 8'h00}) + ADDR_W'(index);

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         parity <= 1'b0;
         index  <= '0;
         page   <= '0;
         data_q <= '0;
         done_q <= 1'b0;
      end else begin
         parity <= ~parity;
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (trigger) begin
                  page  <= cpu_do[7:0];
                  index <= '0;
                  state <= ST_HALT;
               end
            end
            // parity 1 here means the next cycle is a get cycle, so reads start immediately
            ST_HALT:  state <= parity ? ST_READ : ST_ALIGN;
            ST_ALIGN: state <= ST_READ;
            ST_READ: begin
               data_q <= bus_di;
               state  <= ST_WRITE;
            end
            ST_WRITE: begin
               index <= index_inc;
               if (index_inc < IDX_W'(XFER_LEN)) begin
                  state <= ST_READ;
               end else begin
                  state  <= ST_IDLE;
                  done_q <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      bus_addr = cpu_addr;
      bus_we   = cpu_we;
      bus_do   = cpu_do;
      case (state)
         ST_HALT, ST_ALIGN: bus_we = 1'b0;
         ST_READ: begin
            bus_addr = src_addr;
            bus_we   = 1'b0;
         end
         ST_WRITE: begin
            bus_addr = DEST_ADDR;
            bus_we   = 1'b1;
            bus_do   = data_q;
         end
         default: ;
      endcase
   end

   assign cpu_rdy    = (state == ST_IDLE);
   assign dma_active = ~cpu_rdy;
   assign dma_done   = done_q;

endmodule

// File: tb/tb_oam_dma_engine.sv
// tb/tb_oam_dma_engine.sv - bench for oam_dma_engine at XFER_LEN 256 and 4 against a schedule model
module tb_oam_dma_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cpu_addr;
   logic        cpu_we;
   logic [7:0]  cpu_do;

   logic [15:0] ba_a, ba_b;
   logic        bw_a, bw_b;
   logic [7:0]  bdo_a, bdo_b, bdi_a, bdi_b;
   logic        rdy_a, rdy_b, act_a, act_b, done_a, done_b;

   always #5 clk = ~clk;

   function automatic logic [7:0] mem_f(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   assign bdi_a = mem_f(ba_a);
   assign bdi_b = mem_f(ba_b);

   oam_dma_engine dut_a (
      .clk(clk), .reset(rst), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_do(cpu_do),
      .bus_di(bdi_a), .bus_addr(ba_a), .bus_we(bw_a), .bus_do(bdo_a),
      .cpu_rdy(rdy_a), .dma_active(act_a), .dma_done(done_a)
   );

   oam_dma_engine #(.XFER_LEN(4)) dut_b (
      .clk(clk), .reset(rst), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_do(cpu_do),
      .bus_di(bdi_b), .bus_addr(ba_b), .bus_we(bw_b), .bus_do(bdo_b),
      .cpu_rdy(rdy_b), .dma_active(act_b), .dma_done(done_b)
   );

   logic [15:0] o_addr [2];
   logic        o_we   [2];
   logic [7:0]  o_do   [2];
   logic        o_rdy  [2];
   logic        o_act  [2];
   logic        o_done [2];
   assign o_addr[0] = ba_a;   assign o_addr[1] = ba_b;
   assign o_we[0]   = bw_a;   assign o_we[1]   = bw_b;
   assign o_do[0]   = bdo_a;  assign o_do[1]   = bdo_b;
   assign o_rdy[0]  = rdy_a;  assign o_rdy[1]  = rdy_b;
   assign o_act[0]  = act_a;  assign o_act[1]  = act_b;
   assign o_done[0] = done_a; assign o_done[1] = done_b;

   int checks = 0;
   int failures = 0;
   int k = 0;

   // Cycle index since the last reset edge; its low bit is the engine's get/put parity
   always @(posedge clk) k <= rst ? 0 : k + 1;

   int          xl [2] = '{256, 4};
   int          halt_c [2], r0_c [2], end_c [2];
   logic [7:0]  page_m [2];
   int          stall [2], wr [2], dn [2];
   logic [15:0] first_rd [2], last_rd [2], prev_addr [2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at k=%0d actual=%h required=%h", nm, k, act, exp);
      end
   endtask

   task automatic model_cycle(input int d);
      bit          busy;
      int          j;
      logic [15:0] src;
      busy = (k >= halt_c[d]) && (k < end_c[d]);
      if (busy) begin
         chk("busy_rdy", 32'(o_rdy[d]), 32'd0);
         chk("busy_act", 32'(o_act[d]), 32'd1);
         if (k < r0_c[d]) begin
            chk("halt_we", 32'(o_we[d]), 32'd0);
            chk("halt_addr", 32'(o_addr[d]), 32'(cpu_addr));
         end else begin
            j = k - r0_c[d];
            src = 16'({page_m[d], 8'h00} + (j / 2));
            if (j % 2 == 0) begin
               chk("rd_addr", 32'(o_addr[d]), 32'(src));
               chk("rd_we", 32'(o_we[d]), 32'd0);
            end else begin
               chk("wr_addr", 32'(o_addr[d]), 32'h2004);
               chk("wr_we", 32'(o_we[d]), 32'd1);
               chk("wr_data", 32'(o_do[d]), 32'(mem_f(src)));
            end
         end
      end else begin
         chk("idle_rdy", 32'(o_rdy[d]), 32'd1);
         chk("idle_act", 32'(o_act[d]), 32'd0);
         chk("pass_addr", 32'(o_addr[d]), 32'(cpu_addr));
         chk("pass_we", 32'(o_we[d]), 32'(cpu_we));
         chk("pass_do", 32'(o_do[d]), 32'(cpu_do));
      end
      chk("done", 32'(o_done[d]), 32'(k == end_c[d]));

      if (!o_rdy[d]) stall[d]++;
      if (o_act[d] && o_we[d]) begin
         wr[d]++;
         if (wr[d] == 1) first_rd[d] = prev_addr[d];
         last_rd[d] = prev_addr[d];
      end
      if (o_done[d]) dn[d]++;
      prev_addr[d] = o_addr[d];

      if (!busy && cpu_we && cpu_addr == 16'h4014) begin
         halt_c[d] = k + 1;
         r0_c[d]   = k + 2 + (((k + 1) % 2 == 0) ? 1 : 0);
         end_c[d]  = r0_c[d] + 2 * xl[d];
         page_m[d] = cpu_do;
      end
   endtask

   always begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            halt_c[d] = -10;
            r0_c[d]   = -10;
            end_c[d]  = -10;
         end else begin
            model_cycle(d);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cpu_addr = 16'($urandom);
      cpu_we   = 1'($urandom_range(0, 1));
      cpu_do   = 8'($urandom);
      if (cpu_addr == 16'h4014) cpu_addr = 16'h4015;
   endtask

   task automatic clear_meas();
      for (int d = 0; d < 2; d++) begin
         stall[d] = 0;
         wr[d]    = 0;
         dn[d]    = 0;
      end
   endtask

   task automatic trigger(input logic [7:0] pg, input int par);
      tick();
      while (k % 2 != par) tick();
      cpu_addr = 16'h4014;
      cpu_we   = 1'b1;
      cpu_do   = pg;
   endtask

   task automatic wait_done(input int d, input int bound);
      int n = 0;
      tick();
      while (dn[d] == 0 && n < bound) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      rst = 1'b1;
      cpu_addr = 16'h1234;
      cpu_we = 1'b0;
      cpu_do = 8'h00;
      for (int d = 0; d < 2; d++) begin
         halt_c[d] = -10; r0_c[d] = -10; end_c[d] = -10;
         page_m[d] = '0; prev_addr[d] = '0; first_rd[d] = '0; last_rd[d] = '0;
      end
      clear_meas();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_rdy", 32'(rdy_a), 32'd1);
      chk("reset_act", 32'(act_a), 32'd0);
      chk("reset_done", 32'(done_a), 32'd0);
      chk("reset_pass", 32'(ba_a), 32'h1234);

      // Near-miss addresses must not start a transfer
      clear_meas();
      tick(); cpu_addr = 16'h4015; cpu_we = 1'b1; cpu_do = 8'h02;
      tick(); cpu_addr = 16'h4014; cpu_we = 1'b0; cpu_do = 8'h02;
      repeat (5) tick();
      chk("nomatch_stall_a", 32'(stall[0]), 32'd0);
      chk("nomatch_stall_b", 32'(stall[1]), 32'd0);

      // Trigger on a put cycle: HALT lands on get, ALIGN inserted
      clear_meas();
      trigger(8'h02, 1);
      wait_done(0, 1200);
      repeat (2) tick();
      chk("align_stall_a", 32'(stall[0]), 32'd514);
      chk("align_wr_a", 32'(wr[0]), 32'd256);
      chk("align_first_a", 32'(first_rd[0]), 32'h0200);
      chk("align_last_a", 32'(last_rd[0]), 32'h02FF);
      chk("align_done_a", 32'(dn[0]), 32'd1);
      chk("align_stall_b", 32'(stall[1]), 32'd10);
      chk("align_last_b", 32'(last_rd[1]), 32'h0203);

      // Trigger on a get cycle, then a retrigger mid-transfer that must be ignored
      clear_meas();
      trigger(8'h02, 0);
      repeat (4) tick();
      cpu_addr = 16'h4014; cpu_we = 1'b1; cpu_do = 8'h33;
      wait_done(0, 1200);
      tick();
      chk("noalign_stall_a", 32'(stall[0]), 32'd513);
      chk("retrig_wr_a", 32'(wr[0]), 32'd256);
      chk("retrig_last_a", 32'(last_rd[0]), 32'h02FF);
      chk("noalign_stall_b", 32'(stall[1]), 32'd9);
      chk("retrig_wr_b", 32'(wr[1]), 32'd4);
      chk("retrig_last_b", 32'(last_rd[1]), 32'h0203);

      // Top page
      clear_meas();
      trigger(8'hFF, 1);
      wait_done(0, 1200);
      tick();
      chk("ff_first_b", 32'(first_rd[1]), 32'hFF00);
      chk("ff_last_b", 32'(last_rd[1]), 32'hFF03);
      chk("ff_wr_b", 32'(wr[1]), 32'd4);
      chk("ff_stall_b", 32'(stall[1]), 32'd10);
      chk("ff_last_a", 32'(last_rd[0]), 32'hFFFF);

      // Trigger in the dma_done cycle of the short engine
      clear_meas();
      trigger(8'h05, 0);
      n = 0;
      tick();
      while (!done_b && n < 50) begin
         tick();
         n++;
      end
      cpu_addr = 16'h4014; cpu_we = 1'b1; cpu_do = 8'h07;
      wait_done(0, 1200);
      tick();
      chk("chain_done_b", 32'(dn[1]), 32'd2);
      chk("chain_wr_b", 32'(wr[1]), 32'd8);
      chk("chain_last_b", 32'(last_rd[1]), 32'h0703);
      chk("chain_stall_b", 32'(stall[1]), 32'd18);

      // Reset after 10 bytes aborts the long transfer
      clear_meas();
      trigger(8'h01, 1);
      n = 0;
      tick();
      while (wr[0] < 10 && n < 100) begin
         tick();
         n++;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_rdy", 32'(rdy_a), 32'd1);
      chk("abort_act", 32'(act_a), 32'd0);
      chk("abort_pass_addr", 32'(ba_a), 32'(cpu_addr));
      chk("abort_pass_we", 32'(bw_a), 32'(cpu_we));
      repeat (600) tick();
      chk("abort_no_done", 32'(dn[0]), 32'd0);
      chk("abort_wr", 32'(wr[0]), 32'd10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
